// File: rtl/riscv_hazard_pkg.sv
// Shared definitions for the RV32I hazard controller: forward-select codes,
// memory-wait FSM state encoding and the forwarding priority helper.
package riscv_hazard_pkg;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WAIT  = 2'b01,
    ABORT = 2'b10
  } mem_state_t;

  // Picks the youngest in-flight producer of rs; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] rd_m,
                                         input logic       we_m,
                                         input logic [4:0] rd_w,
                                         input logic       we_w);
    logic [1:0] sel;
    if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = FWD_MEM;
    end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_NONE;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of pipeline-register hazard signals between the datapath (master)
// and the hazard controller (slave).
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 32);
  logic [4:0]       Rs1_D, Rs2_D;
  logic [4:0]       Rs1_E, Rs2_E, Rd_E;
  logic [4:0]       Rd_M, Rd_W;
  logic             RegWrite_M, RegWrite_W;
  logic             ResultSrc_E0;
  logic             PCSrc_E;
  logic             MemReq_M;
  logic             MemReady;
  logic [1:0]       ForwardA_E, ForwardB_E;
  logic             Stall_F, Stall_D, Stall_E, Stall_M;
  logic             Flush_D, Flush_E, Flush_W;
  logic             MemBusy;
  logic             MemTimeout;
  logic [CNT_W-1:0] LoadStallCnt, BranchFlushCnt, MemWaitCnt;

  modport master (
    output Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W,
    output RegWrite_M, RegWrite_W, ResultSrc_E0, PCSrc_E, MemReq_M, MemReady,
    input  ForwardA_E, ForwardB_E, Stall_F, Stall_D, Stall_E, Stall_M,
    input  Flush_D, Flush_E, Flush_W, MemBusy, MemTimeout,
    input  LoadStallCnt, BranchFlushCnt, MemWaitCnt
  );

  modport slave (
    input  Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W,
    input  RegWrite_M, RegWrite_W, ResultSrc_E0, PCSrc_E, MemReq_M, MemReady,
    output ForwardA_E, ForwardB_E, Stall_F, Stall_D, Stall_E, Stall_M,
    output Flush_D, Flush_E, Flush_W, MemBusy, MemTimeout,
    output LoadStallCnt, BranchFlushCnt, MemWaitCnt
  );
endinterface

// File: rtl/hazard_mem_wait_fsm.sv
// Memory-wait freeze FSM. The wait counter already counts the IDLE cycle that
// starts a wait, so a timeout yields exactly MEM_TIMEOUT freeze cycles
// followed by one non-freezing ABORT cycle. The timeout flag is sticky.
module hazard_mem_wait_fsm
  import riscv_hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_req,
  input  logic mem_ready,
  output logic freeze,
  output logic abort,
  output logic mem_timeout
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

  mem_state_t        state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;

  // Next state, wait count, sticky timeout and freeze/abort decode.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    freeze     = 1'b0;
    abort      = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_req && !mem_ready) begin
          freeze     = 1'b1;
          state_d    = WAIT;
          wait_cnt_d = WCNT_ONE;
        end else begin
          state_d    = IDLE;
          wait_cnt_d = '0;
        end
      end
      WAIT: begin
        if (mem_ready) begin
          state_d    = IDLE;
          wait_cnt_d = '0;
        end else begin
          freeze = 1'b1;
          if (wait_cnt_q >= WCNT_LAST) begin
            state_d    = ABORT;
            timeout_d  = 1'b1;
            wait_cnt_d = '0;
          end else begin
            wait_cnt_d = wait_cnt_q + WCNT_ONE;
          end
        end
      end
      ABORT: begin
        abort      = 1'b1;
        state_d    = IDLE;
        wait_cnt_d = '0;
      end
      default: begin
        state_d    = IDLE;
        wait_cnt_d = '0;
      end
    endcase
    mem_timeout = timeout_q;
  end

  // State, wait counter and timeout flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall controller for the five-stage RV32I pipeline: EX-stage
// forwarding, load-use stalls, taken-branch flushes and memory-wait freeze.
// Optional performance counters are built when HAZARD_PERF_EN is defined;
// otherwise the counter outputs are tied to zero.
module pipeline_hazard_ctrl
  import riscv_hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  pipeline_hazard_ctrl_if.slave  hz
);

  logic lw_stall_s;
  logic freeze_raw_s;
  logic abort_s;
  logic freeze_s;
  logic mem_timeout_s;

  hazard_mem_wait_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem_wait_fsm (
    .clk         (clk),
    .rst         (rst),
    .mem_req     (hz.MemReq_M),
    .mem_ready   (hz.MemReady),
    .freeze      (freeze_raw_s),
    .abort       (abort_s),
    .mem_timeout (mem_timeout_s)
  );

  // Load-use detection and effective freeze (ABORT never freezes).
  always_comb begin
    lw_stall_s = hz.ResultSrc_E0 && (hz.Rd_E != 5'd0) &&
                 ((hz.Rd_E == hz.Rs1_D) || (hz.Rd_E == hz.Rs2_D));
    freeze_s   = freeze_raw_s && !abort_s;
  end

  // Forward selects, stalls and flushes; freeze overrides branch flushes.
  always_comb begin
    hz.ForwardA_E = fwd_sel(hz.Rs1_E, hz.Rd_M, hz.RegWrite_M, hz.Rd_W, hz.RegWrite_W);
    hz.ForwardB_E = fwd_sel(hz.Rs2_E, hz.Rd_M, hz.RegWrite_M, hz.Rd_W, hz.RegWrite_W);
    hz.Stall_F    = lw_stall_s || freeze_s;
    hz.Stall_D    = lw_stall_s || freeze_s;
    hz.Stall_E    = freeze_s;
    hz.Stall_M    = freeze_s;
    hz.Flush_D    = hz.PCSrc_E && !freeze_s;
    hz.Flush_E    = (lw_stall_s || hz.PCSrc_E) && !freeze_s;
    hz.Flush_W    = freeze_s;
    hz.MemBusy    = freeze_s;
    hz.MemTimeout = mem_timeout_s;
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] load_stall_cnt_q, load_stall_cnt_d;
  logic [CNT_W-1:0] branch_flush_cnt_q, branch_flush_cnt_d;
  logic [CNT_W-1:0] mem_wait_cnt_q, mem_wait_cnt_d;

  // Saturating event counters.
  always_comb begin
    load_stall_cnt_d   = load_stall_cnt_q;
    branch_flush_cnt_d = branch_flush_cnt_q;
    mem_wait_cnt_d     = mem_wait_cnt_q;
    if (lw_stall_s && !freeze_s && (load_stall_cnt_q != '1)) begin
      load_stall_cnt_d = load_stall_cnt_q + CNT_W'(1);
    end else begin
      load_stall_cnt_d = load_stall_cnt_q;
    end
    if (hz.PCSrc_E && !freeze_s && (branch_flush_cnt_q != '1)) begin
      branch_flush_cnt_d = branch_flush_cnt_q + CNT_W'(1);
    end else begin
      branch_flush_cnt_d = branch_flush_cnt_q;
    end
    if (freeze_s && (mem_wait_cnt_q != '1)) begin
      mem_wait_cnt_d = mem_wait_cnt_q + CNT_W'(1);
    end else begin
      mem_wait_cnt_d = mem_wait_cnt_q;
    end
    hz.LoadStallCnt   = load_stall_cnt_q;
    hz.BranchFlushCnt = branch_flush_cnt_q;
    hz.MemWaitCnt     = mem_wait_cnt_q;
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_stall_cnt_q   <= '0;
      branch_flush_cnt_q <= '0;
      mem_wait_cnt_q     <= '0;
    end else begin
      load_stall_cnt_q   <= load_stall_cnt_d;
      branch_flush_cnt_q <= branch_flush_cnt_d;
      mem_wait_cnt_q     <= mem_wait_cnt_d;
    end
  end
`else
  // Counters absent: ports kept, driven to zero.
  always_comb begin
    hz.LoadStallCnt   = '0;
    hz.BranchFlushCnt = '0;
    hz.MemWaitCnt     = '0;
  end
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and stall controller for the five-stage RV32I pipeline. It drives the stall, flush and forward-select controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves EX-stage forwarding, load-use stalls and taken-branch flushes. It also runs a small FSM that freezes the whole pipeline while the data memory holds off with `MemReady` low, and bounds that wait with a timeout.

## Interface
- `MEM_TIMEOUT`, 255: maximum consecutive wait cycles before abort (≥2).
- `CNT_W`, 32: width of the performance counters.
- `clk` in 1: clock.
- `rst` in 1: reset. Synchronous, active-high.
- `Rs1_D`, `Rs2_D` in 5: source registers of the instruction in decode.
- `Rs1_E`, `Rs2_E`, `Rd_E` in 5: source and destination registers in execute.
- `Rd_M`, `Rd_W` in 5: destination registers in memory and writeback.
- `RegWrite_M`, `RegWrite_W` in 1: register-write enables in memory and writeback.
- `ResultSrc_E0` in 1: high when the instruction in execute is a load.
- `PCSrc_E` in 1: branch or jump taken in execute.
- `MemReq_M` in 1: load or store present in the memory stage.
- `MemReady` in 1: data memory completes the access this cycle.
- `ForwardA_E`, `ForwardB_E` out 2: ALU operand select.
- `Stall_F`, `Stall_D`, `Stall_E`, `Stall_M` out 1: hold the PC or pipeline register.
- `Flush_D`, `Flush_E`, `Flush_W` out 1: load a bubble (zeros) into the register.
- `MemBusy` out 1: the memory-wait freeze is active.
- `MemTimeout` out 1: sticky abort flag.
- `LoadStallCnt`, `BranchFlushCnt`, `MemWaitCnt` out `CNT_W`: performance counters.

## Operation
- **Forwarding** (combinational):
  - `ForwardA_E` = `FWD_MEM` (10) if `RegWrite_M` && `Rd_M`≠0 && `Rd_M`==`Rs1_E`.
  - Else `FWD_WB` (01) under the same condition using the W-stage signals.
  - Else `FWD_NONE` (00).
  - `ForwardB_E` follows the same rule using `Rs2_E`.
  - Forwarding from memory beats forwarding from writeback.
- **Load-use stall:** `lwStall` = `ResultSrc_E0` && `Rd_E`≠0 && (`Rd_E`==`Rs1_D` || `Rd_E`==`Rs2_D`).
- **Freeze** (combinational from the FSM state and inputs):
  - `freeze` = (IDLE && `MemReq_M` && !`MemReady`) || (WAIT && !`MemReady`).
- **Memory FSM states:** IDLE, WAIT, ABORT.
  - IDLE→WAIT on `MemReq_M` && !`MemReady`.
  - WAIT→IDLE on `MemReady`.
  - WAIT→ABORT when the wait counter reaches `MEM_TIMEOUT`-1 with `MemReady` low.
  - ABORT→IDLE unconditionally.
- **Wait counter:** cleared in IDLE, increments each WAIT cycle.
- **ABORT state:** `freeze`=0 and `MemTimeout` is set. `MemTimeout` clears only on `rst`.
- **Output equations:**
  - `Stall_F` = `Stall_D` = `lwStall` || `freeze`.
  - `Stall_E` = `Stall_M` = `freeze`.
  - `Flush_D` = `PCSrc_E` && !`freeze`.
  - `Flush_E` = (`lwStall` || `PCSrc_E`) && !`freeze`.
  - `Flush_W` = `freeze`, so the frozen memory-stage instruction does not write back twice.
  - `MemBusy` = `freeze`.
- **Simultaneous events:**
  - `freeze` suppresses branch flushes. `PCSrc_E` stays held in the frozen ID/EX register and is acted on in the first unfrozen cycle.
  - `lwStall` together with `PCSrc_E`: the flush wins for E, and F/D stall for one cycle (harmless, since D is flushed).

## Timing
- Forward selects, stalls and flushes are combinational, with 0-cycle latency from the inputs.
- The FSM state, wait counter, `MemTimeout` and the counters are registered.
- Reset values:
  - state=IDLE, wait counter 0.
  - `MemTimeout`=0, all counters 0.
  - Combinational outputs are 0, given inputs at 0.
- `rst` asserted mid-WAIT returns the FSM to IDLE on the next edge.
- A request answered at once (`MemReady`=1 in the first cycle) causes zero freeze cycles.
- A wait of N cycles gives exactly N cycles of `MemBusy`.
- A timeout gives `MEM_TIMEOUT` freeze cycles, then one ABORT cycle with no freeze.

## Configuration
- Macro: `HAZARD_PERF_EN`.
- **Defined:** the counters are present. Each saturates at all-ones.
  - `LoadStallCnt` increments on `lwStall` && !`freeze`.
  - `BranchFlushCnt` increments on `Flush_D`.
  - `MemWaitCnt` increments on `freeze`.
- **Undefined:** no counter registers. The three counter outputs are tied to 0 and the ports remain, keeping the interface stable.

## Structure
- Package `riscv_hazard_pkg` holds:
  - the `FWD_NONE`/`FWD_WB`/`FWD_MEM` constants;
  - the `mem_state_t` enum (IDLE, WAIT, ABORT).
- Sub-module `hazard_mem_wait_fsm` holds:
  - the state register, wait counter and `MemTimeout`;
  - it outputs `freeze` and `abort`.
- Forwarding, stall and flush logic and the counters live in the top module.

## Test plan
- `Rd_M`=5, `RegWrite_M`=1, `Rd_W`=5, `RegWrite_W`=1, `Rs1_E`=5 -> `ForwardA_E`=10. Same with `Rd_M`=0 -> `ForwardA_E`=01.
- Load in E with `Rd_E`=7 and `Rs2_D`=7 -> `Stall_F`=`Stall_D`=`Flush_E`=1 for one cycle. With `Rd_E`=0 -> no stall.
- `PCSrc_E`=1 with no memory wait -> `Flush_D`=`Flush_E`=1 and `Stall_*`=0.
- `MemReq_M`=1 with `MemReady` low for 3 cycles, and `PCSrc_E`=1 throughout:
  - `MemBusy`=1, `Flush_W`=1 and all `Stall_*`=1 for exactly 3 cycles;
  - `Flush_D`=0 during the wait, then `Flush_D`=1 on the 4th cycle.
- `MEM_TIMEOUT`=4 with `MemReady` held low:
  - 4 freeze cycles, then one cycle with `MemBusy`=0;
  - `MemTimeout`=1 and stays high until `rst`.
- `rst` during WAIT -> next cycle `MemBusy` follows IDLE equations, `MemTimeout`=0, and counters are 0 (`HAZARD_PERF_EN` defined).
